// File: rtl/if_prefetch_queue_pkg.sv
// Shared widths, constants and helpers for the instruction prefetch queue.
// Replaces the legacy Defines.v include for this slice of the codebase.
package if_prefetch_queue_pkg;

  localparam int ADDRESS_LEN     = 32;
  localparam int INSTRUCTION_LEN = 32;
  localparam int PREFETCH_DEPTH  = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Saturating 16-bit add used by the statistics counters.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/if_prefetch_queue_queue_ptr.sv
// Wrap-around pointer counter for the prefetch queue; clr has priority over inc.
// Instantiated once for the read side and once for the write side.
module queue_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch FIFO between fetch and decode, flushed on a taken branch.
// Optional statistics outputs are enabled with `define IF_PREFETCH_QUEUE_STATS_EN.
//
// Handshake: a push happens when in_valid & in_ready at a rising edge, a pop when
// out_valid & out_ready. in_ready/out_valid depend only on registered state, so there
// is no combinational path from any input to the opposite side of the queue.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH   = PREFETCH_DEPTH,
  parameter int ADDR_W  = ADDRESS_LEN,
  parameter int INSTR_W = INSTRUCTION_LEN,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
`ifdef IF_PREFETCH_QUEUE_STATS_EN
  output logic [15:0]        full_stall_cycles,
  output logic [15:0]        flushed_entries,
`endif
  output logic [CW-1:0]      count
);

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // rst gates in_ready so fetch sees the queue as unavailable while held in reset.
  assign in_ready  = rst & ~full;
  assign out_valid = ~empty;
  assign out_pc    = empty ? '0 : pc_mem[rd_ptr];
  assign out_instr = empty ? INSTR_W'(NOP_INSTR) : instr_mem[rd_ptr];
  assign count     = count_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  queue_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst),
    .inc   (push),
    .clr   (flush),
    .ptr   (wr_ptr)
  );

  queue_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst),
    .inc   (pop),
    .clr   (flush),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately left without reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + CW'(1);
    end else if (pop && !push) begin
      count_q <= count_q - CW'(1);
    end
  end

`ifdef IF_PREFETCH_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_stall_cycles <= '0;
      flushed_entries   <= '0;
    end else begin
      if (full && in_valid && !flush) begin
        full_stall_cycles <= sat_add16(full_stall_cycles, 16'd1);
      end
      if (flush) begin
        flushed_entries <= sat_add16(flushed_entries, 16'(count_q));
      end
    end
  end
`endif

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Small instruction prefetch FIFO between the instruction fetch stage and the decode stage.
- Buffers (PC, instruction) pairs so fetch keeps running while decode is stalled by the hazard unit.
- Discards all buffered entries on a taken branch.
- Fetch stalls when the queue is full: fetch's freeze = ~in_ready.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- ADDR_W, `ADDRESS_LEN (32), PC width.
- INSTR_W, `INSTRUCTION_LEN (32), instruction width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  fetch presents a valid PC/instruction pair.
- in_pc  in  ADDR_W  PC (already incremented) of the fetched instruction.
- in_instr  in  INSTR_W  fetched instruction.
- in_ready  out  1  queue can accept a push this cycle.
- flush  in  1  branch taken; discard all contents.
- out_valid  out  1  head entry is valid.
- out_pc  out  ADDR_W  head PC.
- out_instr  out  INSTR_W  head instruction.
- out_ready  in  1  decode consumes the head this cycle (~hazard freeze).
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated at the rising edge of clk.
- Reset (rst low), asynchronous:
  - wr_ptr, rd_ptr and count = 0.
  - out_valid = 0, out_pc = 0, out_instr = `NOP_INSTR (0).
  - in_ready = 0 while rst is low; in_ready = 1 from the first cycle after release.
- Storage entries are not reset. Contents are undefined until written.
- Latency: an entry pushed at edge N is visible on out_* after edge N. Minimum push-to-pop is 1 cycle. There is no combinational fall-through from in_* to out_*.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready, so there is no combinational in→out path.
- out_valid = (count != 0). out_pc and out_instr come from the head entry. When empty they read 0 and `NOP_INSTR.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Full (count==DEPTH): a push is impossible. A pop in that cycle frees a slot, and in_ready rises the next cycle.
- Empty: a pop is impossible. A push makes out_valid = 1 the next cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. count is tracked separately, so full and empty are unambiguous.
- flush is synchronous and has the highest priority. At the edge:
  - count = 0 and wr_ptr = rd_ptr = 0.
  - A same-cycle push and pop are both ignored.
  - The next cycle shows out_valid = 0 and in_ready = 1.
- flush held for multiple cycles keeps the queue empty and drops every push.
- rst asserted mid-operation clears state immediately, regardless of clk.

Optional Feature:
- Macro: IF_PREFETCH_QUEUE_STATS_EN.
- Defined:
  - Adds output full_stall_cycles [15:0]. It increments on every cycle with count==DEPTH & in_valid & !flush.
  - Adds output flushed_entries [15:0]. It adds the pre-flush count on every flush cycle.
  - Both counters saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: the ports and logic are absent. Functional behaviour is identical.

Decomposition:
- Defines.v (shared include) holds:
  - ADDRESS_LEN and INSTRUCTION_LEN.
  - NOP_INSTR, a new 32'h0000_0000 constant.
  - PREFETCH_DEPTH default 4.
- One natural sub-module: queue_ptr, a wrap-around pointer counter with inc, clr and async active-low reset. It is instantiated twice, for read and write.
- Storage is a reg array inside the top module.

Test Plan:
1. Reset release, then push PC=4/instr=32'hE3A00001 with out_ready=0 → the next cycle gives out_valid=1, out_pc=4, count=1, in_ready=1.
2. Push 4 entries (PC 4, 8, 12, 16) with out_ready=0 → count=4, in_ready=0. A 5th in_valid is ignored. Setting out_ready=1 for one cycle gives count=3 and in_ready=1 the next cycle.
3. Continuous push and pop for 10 cycles at count=2 → count stays 2, outputs appear in PC order 4, 8, 12…, and the pointers wrap past 3 with no loss.
4. Queue holds 3 entries; assert flush with in_valid=1 and out_ready=1 → the next cycle gives count=0, out_valid=0, out_instr=0, in_ready=1. The same-cycle push is absent.
5. Queue holds 2 entries; drive rst low between clock edges → count=0 and out_valid=0 immediately, before the next edge.
6. With IF_PREFETCH_QUEUE_STATS_EN: fill the queue and hold in_valid for 5 cycles, then flush → full_stall_cycles=5 and flushed_entries=4.
